ksa_swapper: RTL and testbench

- RC4 key-scheduling engine; the read-modify-write consumer of the S-array that the RAM initializer writes as S[k]=k.
- For i = 0..RAM_SIZE-1: reads S[i], computes j = j + S[i] + key[i mod KEY_LENGTH], reads S[j], then writes the swapped values back.
- Sits beside the initializer under ramcontroller and is selected by the next mode code.
- Drives one port of the shared single-port synchronous S RAM.

---
 rtl/rc4_pkg.sv | 24 ++
 rtl/ksa_swapper.sv | 103 ++++++++++
 tb/tb_ksa_swapper.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/rc4_pkg.sv
// Shared RC4 definitions for the S-array RAM controller slice.
package rc4_pkg;

  localparam int unsigned RAM_WIDTH_DEF  = 8;
  localparam int unsigned RAM_SIZE_DEF   = 256;
  localparam int unsigned KEY_LENGTH_DEF = 3;

  // Mode codes used by ramcontroller to select the active S-array engine.
  localparam logic [2:0] MODE_IDLE = 3'b000;
  localparam logic [2:0] MODE_INIT = 3'b001;
  localparam logic [2:0] MODE_KSA  = 3'b010;

  typedef enum logic [2:0] {
    IDLE,
    READ_I,
    CAPT_I,
    READ_J,
    CAPT_J,
    WRITE_I,
    WRITE_J,
    DONE
  } ksa_state_t;

endpackage

// File: rtl/ksa_swapper.sv
// RC4 key-scheduling engine: read-modify-write swap pass over the S array.
module ksa_swapper
  import rc4_pkg::*;
#(
  parameter int unsigned RAM_WIDTH  = RAM_WIDTH_DEF,
  parameter int unsigned RAM_SIZE   = RAM_SIZE_DEF,
  parameter int unsigned KEY_LENGTH = KEY_LENGTH_DEF
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            start,
  output logic                            finished,
  input  logic [KEY_LENGTH*RAM_WIDTH-1:0] secret_key,
  output logic [RAM_WIDTH-1:0]            address,
  output logic [RAM_WIDTH-1:0]            ram_in,
  output logic                            write_enable,
  input  logic [RAM_WIDTH-1:0]            ram_out
);

  localparam int unsigned KW = (KEY_LENGTH > 1) ? $clog2(KEY_LENGTH) : 1;

  ksa_state_t           state;
  logic [RAM_WIDTH-1:0] i;
  logic [RAM_WIDTH-1:0] j;
  logic [RAM_WIDTH-1:0] si;
  logic [RAM_WIDTH-1:0] sj;
  logic [KW-1:0]        key_idx;
  logic [RAM_WIDTH-1:0] key_byte;

  // Key byte 0 sits in the most significant byte of secret_key.
  always_comb begin
    key_byte = secret_key[(KEY_LENGTH - 32'(key_idx)) * RAM_WIDTH - 1 -: RAM_WIDTH];
  end

  // Sequencer and datapath registers; one cycle per state except IDLE/DONE.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      i       <= '0;
      j       <= '0;
      key_idx <= '0;
      si      <= '0;
      sj      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            i       <= '0;
            j       <= '0;
            key_idx <= '0;
            state   <= READ_I;
          end
        end
        READ_I: state <= CAPT_I;
        CAPT_I: begin
          si    <= ram_out;
          j     <= j + ram_out + key_byte;
          state <= READ_J;
        end
        READ_J: state <= CAPT_J;
        CAPT_J: begin
          sj    <= ram_out;
          state <= WRITE_I;
        end
        WRITE_I: state <= WRITE_J;
        WRITE_J: begin
          i       <= i + 1'b1;
          key_idx <= (key_idx == KW'(KEY_LENGTH - 1)) ? '0 : key_idx + 1'b1;
          state   <= (i == RAM_WIDTH'(RAM_SIZE - 1)) ? DONE : READ_I;
        end
        DONE: begin
          if (!start) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // RAM port and status outputs decoded from state and registers.
  always_comb begin
    address      = '0;
    ram_in       = '0;
    write_enable = 1'b0;
    finished     = 1'b0;
    case (state)
      READ_I, CAPT_I: address = i;
      READ_J, CAPT_J: address = j;
      WRITE_I: begin
        address      = i;
        ram_in       = sj;
        write_enable = 1'b1;
      end
      WRITE_J: begin
        address      = j;
        ram_in       = si;
        write_enable = 1'b1;
      end
      DONE:    finished = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ksa_swapper.sv
// Directed bench for ksa_swapper with a behavioural S RAM and golden KSA model.
module tb_ksa_swapper;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        finished;
  logic [23:0] secret_key;
  logic [7:0]  address;
  logic [7:0]  ram_in;
  logic        write_enable;
  logic [7:0]  ram_out;

  int checks   = 0;
  int failures = 0;

  logic [7:0] mem  [256];
  logic [7:0] img  [256];
  logic [7:0] gold [256];
  logic [7:0] pre  [256];
  logic       ld;
  logic [7:0] q;

  logic [7:0] tr_addr [$];
  logic [7:0] tr_data [$];
  logic       tr_we   [$];
  logic [7:0] wr_addr [$];
  logic [7:0] wr_data [$];

  always #5 clk = ~clk;

  ksa_swapper #(
    .RAM_WIDTH (8),
    .RAM_SIZE  (256),
    .KEY_LENGTH(3)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .finished    (finished),
    .secret_key  (secret_key),
    .address     (address),
    .ram_in      (ram_in),
    .write_enable(write_enable),
    .ram_out     (ram_out)
  );

  // Single-port synchronous RAM, registered address, one-cycle read latency.
  always @(posedge clk) begin
    if (ld) begin
      for (int k = 0; k < 256; k++) mem[k] <= img[k];
    end else if (write_enable) begin
      mem[address] <= ram_in;
    end
    q <= mem[address];
  end
  assign ram_out = q;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic load_img();
    @(negedge clk) ld = 1'b1;
    @(negedge clk) ld = 1'b0;
  endtask

  task automatic set_identity();
    for (int k = 0; k < 256; k++) img[k] = 8'(k);
  endtask

  // Reference KSA applied to the current RAM contents.
  task automatic golden(input logic [23:0] key);
    logic [7:0] jj;
    logic [7:0] kb;
    logic [7:0] t;
    jj = 8'h00;
    for (int k = 0; k < 256; k++) pre[k] = mem[k];
    for (int k = 0; k < 256; k++) gold[k] = mem[k];
    for (int n = 0; n < 256; n++) begin
      kb = 8'(key >> (8 * (2 - (n % 3))));
      jj = jj + gold[n] + kb;
      t = gold[n];
      gold[n] = gold[jj];
      gold[jj] = t;
    end
  endtask

  task automatic compare_mem(input string tag);
    int nm;
    nm = 0;
    for (int k = 0; k < 256; k++) if (mem[k] !== gold[k]) nm++;
    check_val(tag, nm, 0);
  endtask

  task automatic output_zero(input string tag);
    check_val(tag, {finished, write_enable, address, ram_in}, 18'h0);
  endtask

  // Run one pass; edge count includes the edge that samples start.
  task automatic run_ksa(input logic [23:0] key, input bit hold, input string tag);
    int edges;
    secret_key = key;
    tr_addr.delete(); tr_data.delete(); tr_we.delete();
    wr_addr.delete(); wr_data.delete();
    @(negedge clk) start = 1'b1;
    edges = 0;
    while (edges < 3000) begin
      @(posedge clk);
      edges++;
      #1;
      tr_addr.push_back(address);
      tr_data.push_back(ram_in);
      tr_we.push_back(write_enable);
      if (write_enable) begin
        wr_addr.push_back(address);
        wr_data.push_back(ram_in);
      end
      if (!hold && edges == 3) start = 1'b0;
      if (finished) break;
    end
    check_val({tag, "_latency"}, edges, 1537);
  endtask

  initial begin
    int n;
    int nwr;
    int nfin;
    reset = 1'b1;
    start = 1'b0;
    ld = 1'b0;
    secret_key = 24'h0;
    set_identity();
    repeat (3) @(posedge clk);
    #1 output_zero("reset_outputs");
    @(negedge clk) reset = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1 output_zero("idle_outputs");
    end

    // Identity S, zero key: early write trace.
    set_identity();
    load_img();
    golden(24'h000000);
    run_ksa(24'h000000, 1'b0, "key0");
    check_val("key0_w0", {wr_addr[0], wr_data[0]}, 16'h0000);
    check_val("key0_w1", {wr_addr[1], wr_data[1]}, 16'h0000);
    check_val("key0_w2", {wr_addr[2], wr_data[2]}, 16'h0101);
    check_val("key0_w3", {wr_addr[3], wr_data[3]}, 16'h0101);
    check_val("key0_w4", {wr_addr[4], wr_data[4]}, 16'h0203);
    check_val("key0_w5", {wr_addr[5], wr_data[5]}, 16'h0302);
    check_val("key0_nwrites", wr_addr.size(), 512);
    compare_mem("key0_final_S");
    @(posedge clk);
    #1 check_val("key0_back_idle", finished, 1'b0);

    // Identity S, key 0x00033C, start held through DONE.
    set_identity();
    load_img();
    golden(24'h00033C);
    run_ksa(24'h00033C, 1'b1, "key33c");
    check_val("key33c_w2", {wr_addr[2], wr_data[2]}, 16'h0104);
    check_val("key33c_w3", {wr_addr[3], wr_data[3]}, 16'h0401);
    compare_mem("key33c_final_S");
    nwr = 0;
    nfin = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
      #1;
      if (write_enable) nwr++;
      if (!finished) nfin++;
    end
    check_val("hold_no_writes", nwr, 0);
    check_val("hold_finished_low_cycles", nfin, 0);
    @(negedge clk) start = 1'b0;
    @(posedge clk);
    #1 check_val("drop_start_idle", finished, 1'b0);

    // Restart on the permuted S: fresh i=0, j=0.
    golden(24'h00033C);
    run_ksa(24'h00033C, 1'b0, "restart");
    check_val("restart_read_i0", tr_addr[0], 8'h00);
    check_val("restart_read_j0", tr_addr[2], pre[0]);
    compare_mem("restart_final_S");

    // Reset during WRITE_I of iteration 100.
    set_identity();
    load_img();
    secret_key = 24'h0A0B0C;
    @(negedge clk) start = 1'b1;
    n = 0;
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      if (write_enable) begin
        if (n == 200) break;
        n++;
      end
    end
    check_val("midreset_write_index", n, 200);
    check_val("midreset_addr_i100", address, 8'd100);
    reset = 1'b1;
    start = 1'b0;
    @(posedge clk);
    #1 output_zero("midreset_outputs");
    @(negedge clk) reset = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1 output_zero("midreset_idle");
    end
    set_identity();
    load_img();
    golden(24'h0A0B0C);
    run_ksa(24'h0A0B0C, 1'b0, "postreset");
    compare_mem("postreset_final_S");

    // j wraps: 0x20 + 0xF0 + 0xFF = 0x20F -> 0x0F.
    set_identity();
    img[8'h00] = 8'h20;
    img[8'h20] = 8'h00;
    img[8'h01] = 8'hF0;
    img[8'hF0] = 8'h01;
    load_img();
    golden(24'h00FF00);
    run_ksa(24'h00FF00, 1'b0, "wrap");
    check_val("wrap_read_j_iter0", tr_addr[2], 8'h20);
    check_val("wrap_read_j_iter1", tr_addr[8], 8'h0F);
    compare_mem("wrap_final_S");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
